layer_compositor: RTL

- Parametrised successor to the fixed five-meteor paint/collision logic: composites LAYERS CLUT-aligned sprite layers over a background colour by fixed priority.
- Detects per-pixel collisions between one designated player layer and a maskable set of hazard layers.
- Runs a hit/grace FSM that provides sticky death, post-respawn invulnerability and a per-frame collision report.
- Sits between the per-sprite CLUT outputs and the VGA/SDL output registers in the top level.

---
 rtl/compositor_pkg.sv | 23 ++
 rtl/layer_compositor_prio_sel.sv | 25 ++
 rtl/layer_compositor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/compositor_pkg.sv
// Shared types, default widths and helpers for the layer compositor.
package compositor_pkg;

  localparam int unsigned DEF_COLRW = 12;
  localparam int unsigned DEF_CNTW  = 8;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    GRACE = 2'd2
  } state_t;

  // Index of the lowest set bit among the first n bits of v; returns n when none is set.
  function automatic int lowest_set(input logic [31:0] v, input int n);
    int r;
    r = n;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] && (i < n)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/layer_compositor_prio_sel.sv
// Fixed-priority colour select: lowest-index active layer wins, background otherwise.
module layer_compositor_prio_sel
  import compositor_pkg::*;
#(
  parameter int unsigned LAYERS = 8,
  parameter int unsigned COLRW  = DEF_COLRW
) (
  input  logic [LAYERS-1:0]       act,
  input  logic [LAYERS*COLRW-1:0] colr,
  input  logic [COLRW-1:0]        bg,
  output logic [COLRW-1:0]        sel_c
);

  int idx;

  // Pick the winning layer's colour, falling back to the background.
  always_comb begin
    idx   = lowest_set(32'(act), int'(LAYERS));
    sel_c = bg;
    for (int i = 0; i < int'(LAYERS); i++) begin
      if (i == idx) sel_c = colr[i*COLRW +: COLRW];
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Sprite layer compositor with player/hazard collision detection and hit/grace FSM.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned       LAYERS       = 8,
  parameter int unsigned       COLRW        = DEF_COLRW,
  parameter int unsigned       PLAYER       = 0,
  parameter logic [LAYERS-1:0] COLL_MASK    = '1,
  parameter int unsigned       GRACE_FRAMES = 120,
  parameter int unsigned       CNTW         = DEF_CNTW
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    de,
  input  logic                    frame,
  input  logic [LAYERS-1:0]       layer_en,
  input  logic [LAYERS-1:0]       layer_drawing,
  input  logic [LAYERS*COLRW-1:0] layer_colr,
  input  logic [COLRW-1:0]        bg_colr,
  input  logic                    clr_hit,
  output logic [COLRW-1:0]        paint_colr,
  output logic                    paint_de,
  output logic                    paint_frame,
  output logic                    hit,
  output logic                    grace,
  output logic                    hit_pulse,
  output logic [LAYERS-1:0]       hit_mask,
  output logic [CNTW-1:0]         hit_cnt
);

  localparam int unsigned GW = (GRACE_FRAMES == 0) ? 1 : $clog2(GRACE_FRAMES + 1);
  // Layers able to hurt the player; the player never collides with itself.
  localparam logic [LAYERS-1:0] HAZ = COLL_MASK & ~(LAYERS'(1) << PLAYER);

  if (PLAYER >= LAYERS) begin : g_bad_player
    $error("layer_compositor: PLAYER must be below LAYERS");
  end
  if (LAYERS > 32) begin : g_bad_layers
    $error("layer_compositor: LAYERS must not exceed 32");
  end

  state_t            state_q, state_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [LAYERS-1:0] acc_q;
  logic [CNTW-1:0]   cnt_d;
  logic              pulse_d;
  logic [LAYERS-1:0] act_c;
  logic [LAYERS-1:0] haz_c;
  logic              coll_c;
  logic [COLRW-1:0]  sel_c;

  assign act_c  = layer_drawing & layer_en;
  assign haz_c  = act_c & HAZ;
  assign coll_c = de & act_c[PLAYER] & (|haz_c);

  layer_compositor_prio_sel #(
    .LAYERS (LAYERS),
    .COLRW  (COLRW)
  ) u_prio_sel (
    .act   (act_c),
    .colr  (layer_colr),
    .bg    (bg_colr),
    .sel_c (sel_c)
  );

  // Next-state and counter logic for the hit/grace FSM.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    cnt_d   = hit_cnt;
    pulse_d = 1'b0;
    case (state_q)
      ALIVE: begin
        if (coll_c) begin
          state_d = HIT;
          pulse_d = 1'b1;
          if (hit_cnt != '1) cnt_d = hit_cnt + CNTW'(1);
        end
      end
      HIT: begin
        if (clr_hit) begin
          if (GRACE_FRAMES == 0) begin
            state_d = ALIVE;
          end else begin
            state_d = GRACE;
            gcnt_d  = GW'(GRACE_FRAMES);
          end
        end
      end
      GRACE: begin
        if (frame) begin
          gcnt_d = gcnt_q - GW'(1);
          if (gcnt_q == GW'(1)) state_d = ALIVE;
        end
      end
      default: state_d = ALIVE;
    endcase
  end

  // FSM state, registered status outputs and hit counter.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q   <= ALIVE;
      gcnt_q    <= '0;
      hit       <= 1'b0;
      grace     <= 1'b0;
      hit_pulse <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      hit       <= (state_d == HIT);
      grace     <= (state_d == GRACE);
      hit_pulse <= pulse_d;
      hit_cnt   <= cnt_d;
    end
  end

  // Per-frame overlap accumulator; the frame clear takes precedence over that cycle's overlap.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      acc_q    <= '0;
      hit_mask <= '0;
    end else if (frame) begin
      hit_mask <= acc_q;
      acc_q    <= '0;
    end else if (de && act_c[PLAYER]) begin
      acc_q <= acc_q | haz_c;
    end
  end

  // Composited pixel pipeline stage, blanked outside the active area.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      paint_colr  <= '0;
      paint_de    <= 1'b0;
      paint_frame <= 1'b0;
    end else begin
      paint_colr  <= de ? sel_c : '0;
      paint_de    <= de;
      paint_frame <= frame;
    end
  end

endmodule
